// File: rtl/btn_pkg.sv
// Shared types and width helper for the multi-channel push-button conditioner.
package btn_pkg;

  typedef enum logic [1:0] {IDLE, HELD, LONG} btn_state_t;

  // Counter width that holds 0..max_val, never narrower than one bit.
  function automatic int cnt_w(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/btn_channel.sv
// One button channel: stability counter, IDLE/HELD/LONG FSM and registered outputs.
module btn_channel
  import btn_pkg::*;
#(
  parameter int STABLE_CNT     = 8,
  parameter int LONG_SAMPLES   = 1000,
  parameter int REPEAT_SAMPLES = 100
) (
  input  logic CLK,
  input  logic RST,
  input  logic p,
  input  logic tick,
  input  logic REPEAT_EN,
  output logic blevel,
  output logic bpress,
  output logic brelease,
  output logic blong,
  output logic brep
);

  localparam int STAB_W = cnt_w(STABLE_CNT - 1);
  localparam int HOLD_W = cnt_w(LONG_SAMPLES - 1);
  localparam int REP_W  = cnt_w(REPEAT_SAMPLES - 1);

  localparam logic [STAB_W-1:0] STAB_MAX = STAB_W'(STABLE_CNT - 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(LONG_SAMPLES - 1);
  localparam logic [REP_W-1:0]  REP_MAX  = REP_W'(REPEAT_SAMPLES - 1);

  btn_state_t        state_q, state_d;
  logic [STAB_W-1:0] stab_q, stab_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [REP_W-1:0]  rep_q, rep_d;
  logic              level_d, press_d, release_d, long_d, rep_pulse_d;
  logic              differ, accept;

  always_comb begin
    // NOTE: every combinational output gets a default first so no latch is inferred.
    state_d     = state_q;
    stab_d      = stab_q;
    hold_d      = hold_q;
    rep_d       = rep_q;
    level_d     = blevel;
    press_d     = 1'b0;
    release_d   = 1'b0;
    long_d      = 1'b0;
    rep_pulse_d = 1'b0;
    differ      = (p != blevel);
    accept      = differ && (stab_q == STAB_MAX);

    if (tick) begin
      if (!differ || accept) stab_d = '0;
      else                   stab_d = stab_q + 1'b1;

      if (accept) level_d = p;

      // Release is checked first in HELD/LONG so it wins over long/repeat.
      unique case (state_q)
        IDLE: begin
          if (accept && p) begin
            state_d     = HELD;
            press_d     = 1'b1;
            rep_pulse_d = 1'b1;
            hold_d      = '0;
          end
        end
        HELD: begin
          if (accept) begin
            state_d   = IDLE;
            release_d = 1'b1;
            hold_d    = '0;
            rep_d     = '0;
          end else if (hold_q == HOLD_MAX) begin
            state_d = LONG;
            long_d  = 1'b1;
            rep_d   = '0;
          end else begin
            hold_d = hold_q + 1'b1;
          end
        end
        LONG: begin
          if (accept) begin
            state_d   = IDLE;
            release_d = 1'b1;
            hold_d    = '0;
            rep_d     = '0;
          end else if (rep_q == REP_MAX) begin
            rep_d       = '0;
            rep_pulse_d = REPEAT_EN;
          end else begin
            rep_d = rep_q + 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q  <= IDLE;
      stab_q   <= '0;
      hold_q   <= '0;
      rep_q    <= '0;
      blevel   <= 1'b0;
      bpress   <= 1'b0;
      brelease <= 1'b0;
      blong    <= 1'b0;
      brep     <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so all state updates together at the edge.
      state_q  <= state_d;
      stab_q   <= stab_d;
      hold_q   <= hold_d;
      rep_q    <= rep_d;
      blevel   <= level_d;
      bpress   <= press_d;
      brelease <= release_d;
      blong    <= long_d;
      brep     <= rep_pulse_d;
    end
  end

endmodule

// File: rtl/btn_debounce_multi.sv
// Multi-channel push-button conditioner: synchronisers, shared sample prescaler, per-channel logic.
module btn_debounce_multi
  import btn_pkg::*;
#(
  parameter int N_BTN          = 4,
  parameter int CLK_HZ         = 50000000,
  parameter int SAMPLE_HZ      = 1000,
  parameter int STABLE_CNT     = 8,
  parameter int LONG_SAMPLES   = 1000,
  parameter int REPEAT_SAMPLES = 100
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [N_BTN-1:0] nBIN,
  input  logic             REPEAT_EN,
  output logic [N_BTN-1:0] BLEVEL,
  output logic [N_BTN-1:0] BPRESS,
  output logic [N_BTN-1:0] BRELEASE,
  output logic [N_BTN-1:0] BLONG,
  output logic [N_BTN-1:0] BREP
);

  localparam int               DIV     = CLK_HZ / SAMPLE_HZ;
  localparam int               PRE_W   = cnt_w(DIV - 1);
  localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(DIV - 1);

  logic [N_BTN-1:0] sync_1, sync_2, p;
  logic [PRE_W-1:0] pre_cnt;
  logic             tick;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      // NOTE: synchroniser flops reset to 1 so every button reads released until sampled.
      sync_1 <= '1;
      sync_2 <= '1;
    end else begin
      sync_1 <= nBIN;
      sync_2 <= sync_1;
    end
  end

  assign p = ~sync_2;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST)                   pre_cnt <= '0;
    else if (pre_cnt == PRE_MAX) pre_cnt <= '0;
    else                       pre_cnt <= pre_cnt + 1'b1;
  end

  assign tick = (pre_cnt == PRE_MAX);

  for (genvar i = 0; i < N_BTN; i++) begin : g_ch
    btn_channel #(
      .STABLE_CNT    (STABLE_CNT),
      .LONG_SAMPLES  (LONG_SAMPLES),
      .REPEAT_SAMPLES(REPEAT_SAMPLES)
    ) u_ch (
      .CLK      (CLK),
      .RST      (RST),
      .p        (p[i]),
      .tick     (tick),
      .REPEAT_EN(REPEAT_EN),
      .blevel   (BLEVEL[i]),
      .bpress   (BPRESS[i]),
      .brelease (BRELEASE[i]),
      .blong    (BLONG[i]),
      .brep     (BREP[i])
    );
  end

endmodule

// File: tb/tb_btn_debounce_multi.sv
// Directed and randomized bench for btn_debounce_multi against a sample-level behavioural model.
module tb_btn_debounce_multi;

  localparam int N      = 4;
  localparam int CLK_HZ = 1000;
  localparam int SMP_HZ = 100;
  localparam int DIV    = CLK_HZ / SMP_HZ;
  localparam int STABLE = 3;
  localparam int LONG   = 20;
  localparam int REP    = 5;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [N-1:0] nbin = '1;
  logic         rep_en = 1'b0;
  logic [N-1:0] blevel, bpress, brelease, blong, brep;

  btn_debounce_multi #(
    .N_BTN(N), .CLK_HZ(CLK_HZ), .SAMPLE_HZ(SMP_HZ),
    .STABLE_CNT(STABLE), .LONG_SAMPLES(LONG), .REPEAT_SAMPLES(REP)
  ) dut (
    .CLK(clk), .RST(rst), .nBIN(nbin), .REPEAT_EN(rep_en),
    .BLEVEL(blevel), .BPRESS(bpress), .BRELEASE(brelease), .BLONG(blong), .BREP(brep)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Behavioural model: per-sample run lengths and hold ages, no FSM encoding.
  bit   [N-1:0] m_level;
  int           m_run [N];
  int           m_held[N];
  int           m_cnt;
  logic [N-1:0] prev1, prev2;
  logic [N-1:0] e_level, e_press, e_rel, e_long, e_rep;

  int c_press[N], c_rel[N], c_long[N], c_rep[N];
  int c_simul;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_update();
    logic [N-1:0] p;
    if (rst) begin
      m_level = '0;
      for (int i = 0; i < N; i++) begin m_run[i] = 0; m_held[i] = 0; end
      m_cnt = 0; prev1 = '1; prev2 = '1;
      e_level = '0; e_press = '0; e_rel = '0; e_long = '0; e_rep = '0;
    end else begin
      p = ~prev2;
      e_press = '0; e_rel = '0; e_long = '0; e_rep = '0;
      if (m_cnt == DIV - 1) begin
        for (int i = 0; i < N; i++) begin
          bit acc;
          acc = 1'b0;
          if (p[i] != m_level[i]) begin
            m_run[i]++;
            if (m_run[i] == STABLE) begin acc = 1'b1; m_level[i] = p[i]; m_run[i] = 0; end
          end else begin
            m_run[i] = 0;
          end
          if (acc && m_level[i]) begin
            e_press[i] = 1'b1; e_rep[i] = 1'b1; m_held[i] = 0;
          end else if (acc) begin
            e_rel[i] = 1'b1;
          end else if (m_level[i]) begin
            m_held[i]++;
            if (m_held[i] == LONG) e_long[i] = 1'b1;
            else if (m_held[i] > LONG && (m_held[i] - LONG) % REP == 0) e_rep[i] = rep_en;
          end
        end
      end
      e_level = m_level;
      prev2 = prev1;
      prev1 = nbin;
      m_cnt = (m_cnt == DIV - 1) ? 0 : m_cnt + 1;
    end
  endtask

  task automatic compare();
    check("blevel",   32'(blevel),   32'(e_level));
    check("bpress",   32'(bpress),   32'(e_press));
    check("brelease", 32'(brelease), 32'(e_rel));
    check("blong",    32'(blong),    32'(e_long));
    check("brep",     32'(brep),     32'(e_rep));
    for (int i = 0; i < N; i++) begin
      c_press[i] += int'(bpress[i]);
      c_rel[i]   += int'(brelease[i]);
      c_long[i]  += int'(blong[i]);
      c_rep[i]   += int'(brep[i]);
    end
    if (bpress == 4'b1001) c_simul++;
  endtask

  task automatic run(input int n);
    repeat (n) begin
      @(posedge clk);
      model_update();
      @(negedge clk);
      compare();
    end
  endtask

  task automatic clr_counts();
    for (int i = 0; i < N; i++) begin c_press[i] = 0; c_rel[i] = 0; c_long[i] = 0; c_rep[i] = 0; end
    c_simul = 0;
  endtask

  function automatic int total_pulses();
    int s = 0;
    for (int i = 0; i < N; i++) s += c_press[i] + c_rel[i] + c_long[i] + c_rep[i];
    return s;
  endfunction

  initial begin
    clr_counts();
    // Reset held with every button pressed: outputs must stay 0.
    rst = 1'b1; nbin = 4'b0000;
    run(50);
    check("rst_no_pulses", 32'(total_pulses()), 32'd0);
    nbin = 4'b1110;
    rst  = 1'b0;
    run(60);
    check("rst_press_ch0", 32'(c_press[0]), 32'd1);
    check("rst_press_other", 32'(c_press[1] + c_press[2] + c_press[3]), 32'd0);
    check("rst_no_release", 32'(c_rel[0] + c_rel[1] + c_rel[2] + c_rel[3]), 32'd0);
    nbin = 4'b1111;
    run(60);

    // Bounce on ch0 every 7 clocks, then a solid press.
    clr_counts();
    for (int k = 0; k < 10; k++) begin
      nbin[0] = ~nbin[0];
      run(7);
    end
    nbin[0] = 1'b0;
    run(100);
    check("bounce_press", 32'(c_press[0]), 32'd1);
    check("bounce_level", 32'(blevel[0]), 32'd1);
    check("bounce_no_rel", 32'(c_rel[0]), 32'd0);
    nbin = 4'b1111;
    run(60);

    // Two-sample glitch on ch1 must be rejected.
    clr_counts();
    nbin[1] = 1'b0;
    run(20);
    nbin[1] = 1'b1;
    run(60);
    check("glitch_level", 32'(blevel[1]), 32'd0);
    check("glitch_no_pulses", 32'(total_pulses()), 32'd0);

    // Long press with auto-repeat on ch2.
    clr_counts();
    rep_en = 1'b1;
    nbin[2] = 1'b0;
    run(400);
    nbin[2] = 1'b1;
    run(60);
    check("long_press", 32'(c_press[2]), 32'd1);
    check("long_blong", 32'(c_long[2]), 32'd1);
    check("long_brep", 32'(c_rep[2]), 32'd4);
    check("long_release", 32'(c_rel[2]), 32'd1);

    // Same hold without auto-repeat.
    clr_counts();
    rep_en = 1'b0;
    nbin[2] = 1'b0;
    run(400);
    nbin[2] = 1'b1;
    run(60);
    check("norep_blong", 32'(c_long[2]), 32'd1);
    check("norep_brep", 32'(c_rep[2]), 32'd1);
    check("norep_release", 32'(c_rel[2]), 32'd1);

    // Simultaneous press on ch0 and ch3.
    clr_counts();
    nbin = 4'b0110;
    run(40);
    check("simul_press_cycle", 32'(c_simul), 32'd1);
    check("simul_level", 32'(blevel), 32'h9);
    nbin = 4'b1111;
    run(60);

    // Reset while ch1 is in the long-press phase.
    clr_counts();
    rep_en = 1'b1;
    nbin[1] = 1'b0;
    run(260);
    check("midrst_long", 32'(c_long[1]), 32'd1);
    clr_counts();
    rst = 1'b1;
    run(1);
    check("midrst_level", 32'(blevel), 32'd0);
    rst = 1'b0;
    run(60);
    check("midrst_no_rel", 32'(c_rel[1]), 32'd0);
    check("midrst_repress", 32'(c_press[1]), 32'd1);
    nbin = 4'b1111;
    run(60);

    // Randomized segments on all channels.
    for (int k = 0; k < 30; k++) begin
      nbin   = 4'($urandom);
      rep_en = 1'($urandom_range(0, 1));
      run($urandom_range(5, 300));
    end
    nbin = 4'b1111;
    run(60);
    check("final_level", 32'(blevel), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/btn_debounce_multi.md
Name: btn_debounce_multi

Overview:
- Parametrised multi-channel push-button conditioner; successor of the fixed 3-button 40 Hz edge detector.
- Synchronises active-low raw buttons and debounces each over a configurable number of stable samples.
- Emits a registered level plus one-clock press, release, long-press and auto-repeat pulses per channel.
- Sits between board push-buttons and control FSMs (clock setting, mode select).

Parameters:
- N_BTN, 4, number of button channels
- CLK_HZ, 50000000, CLK frequency in Hz
- SAMPLE_HZ, 1000, debounce sample rate; DIV = CLK_HZ/SAMPLE_HZ, must be >= 2
- STABLE_CNT, 8, consecutive differing samples needed to accept a level change; must be >= 1
- LONG_SAMPLES, 1000, held samples after accepted press before BLONG fires; must be >= 1
- REPEAT_SAMPLES, 100, samples between auto-repeat pulses after BLONG; must be >= 1

Ports:
- CLK  in  1  system clock
- RST  in  1  reset, asynchronous, active-high
- nBIN  in  N_BTN  raw buttons, active-low, asynchronous to CLK
- REPEAT_EN  in  1  global enable for auto-repeat (synchronous)
- BLEVEL  out  N_BTN  debounced level, 1 = pressed
- BPRESS  out  N_BTN  1-clock pulse on accepted press
- BRELEASE  out  N_BTN  1-clock pulse on accepted release
- BLONG  out  N_BTN  1-clock pulse when hold reaches LONG_SAMPLES
- BREP  out  N_BTN  1-clock pulse on press and on each auto-repeat

Behaviour:
- Reset: clock has one clock and reset is asynchronous, active-high (CLK, RST). All outputs 0. Synchroniser flops reset to 1 (released). Prescaler, stability and hold counters reset to 0. FSMs reset to IDLE.
- Synchroniser: 2 flops per channel, clocked every CLK. Inverted output gives p[i], 1 = pressed.
- Prescaler: counts 0..DIV-1. tick = (cnt == DIV-1). Wraps to 0. One tick serves all channels.
- Stability, per channel, evaluated only on tick:
  - If p[i] != BLEVEL[i]: increment stab.
  - Otherwise: clear stab to 0.
  - When stab reaches STABLE_CNT-1 and p[i] still differs, the level toggles on this tick and stab clears.
  - STABLE_CNT=1 means the level changes on the first differing sample.
- Output timing: all outputs are registered. BLEVEL changes, and any pulse asserts, in the CLK cycle after the deciding tick. Pulses deassert on the next cycle.
- FSM per channel: IDLE, HELD, LONG.
  - IDLE -> HELD on accepted press: BPRESS=1, BREP=1, hold=0.
  - In HELD: hold increments each tick. When hold reaches LONG_SAMPLES-1, go to LONG, BLONG=1, rep=0.
  - In LONG: rep increments each tick. When rep reaches REPEAT_SAMPLES-1, rep clears, and BREP=1 if REPEAT_EN, else no pulse.
  - REPEAT_EN is sampled on the deciding tick. Deasserting it stops pulses but the FSM stays in LONG.
  - Accepted release from HELD or LONG -> IDLE: BRELEASE=1, hold and rep cleared, no BLONG or BREP that cycle.
- Counter widths: $clog2 of max+1. No wrap, because the FSM leaves or clears before the maximum.
- Simultaneous events: channels are fully independent, so any subset may pulse in the same cycle. Release takes priority over a long or repeat event on the same tick.
- Reset mid-operation: outputs drop to 0 immediately. No BRELEASE is generated. After reset, a button still held is re-accepted as a new press after STABLE_CNT ticks.
- Between ticks, FSM and stability state are frozen.

Decomposition:
- Package btn_pkg:
  - typedef enum logic [1:0] {IDLE, HELD, LONG} btn_state_t
  - width helper localparams computed from the parameters
- Sub-module btn_channel: one channel's stability counter, FSM and output registers. Inputs: p, tick, REPEAT_EN. Instantiated N_BTN times via generate.
- Top level: prescaler and synchronisers.

Test Plan (N_BTN=4, CLK_HZ=1000, SAMPLE_HZ=100 so DIV=10, STABLE_CNT=3, LONG_SAMPLES=20, REPEAT_SAMPLES=5):
- Reset: RST=1 for 50 clocks with nBIN=4'b0000 -> all outputs 0 throughout. After RST=0, with ch0 held and others released, BPRESS=4'b0001 once after 3 ticks. No BRELEASE at any time.
- Bounce: nBIN[0] toggles every 7 clocks for 70 clocks, then held low 100 clocks -> exactly one BPRESS[0]; BLEVEL[0]=1; BRELEASE[0] never.
- Glitch: nBIN[1] low for exactly 2 ticks (20 clocks) -> BLEVEL[1] stays 0; no pulses on any output.
- Long and repeat:
  - Stimulus: REPEAT_EN=1, ch2 held 40 ticks, then released.
  - BPRESS and BREP at press acceptance (P).
  - BLONG at P+20 ticks; BREP at P+25, P+30, P+35.
  - BRELEASE 3 ticks after release; BREP count = 4.
  - Same stimulus with REPEAT_EN=0 -> BREP only at P.
- Simultaneous: nBIN[0] and nBIN[3] fall in the same clock -> BPRESS=4'b1001 in a single cycle, BLEVEL=4'b1001.
- Reset mid-hold: ch1 in LONG, RST pulsed for 1 clock -> all outputs 0 next edge. No BRELEASE. Re-press accepted 3 ticks after reset.
